// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus: requester payloads, ROB branch controls, grant and broadcast.
// master = requesters/ROB side, slave = arbiter side.
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif
`ifndef ZERO_REG
`define ZERO_REG {`PRF_IDX_W{1'b0}}
`endif

interface cdb_arbiter_if;
   logic [3:0]                  req_vld_i;
   logic [4*`PRF_IDX_W-1:0]     req_tag_i;
   logic [4*64-1:0]             req_value_i;
   logic [4*(`ROB_IDX_W+1)-1:0] req_rob_idx_i;
   logic [4*`BR_MASK_W-1:0]     req_br_mask_i;
   logic                        rob_br_recovery_i;
   logic                        rob_br_pred_correct_i;
   logic [`BR_MASK_W-1:0]       rob_br_tag_fix_i;
   logic [3:0]                  req_gnt_o;
   logic                        cdb_vld_o;
   logic [`PRF_IDX_W-1:0]       cdb_tag_o;
   logic [63:0]                 cdb_value_o;
   logic [`ROB_IDX_W:0]         cdb_rob_idx_o;
   logic [`BR_MASK_W-1:0]       cdb_br_mask_o;
   logic [1:0]                  cdb_src_o;

   modport master (
      output req_vld_i, req_tag_i, req_value_i,
      output req_rob_idx_i, req_br_mask_i,
      output rob_br_recovery_i, rob_br_pred_correct_i,
      output rob_br_tag_fix_i,
      input  req_gnt_o, cdb_vld_o, cdb_tag_o,
      input  cdb_value_o, cdb_rob_idx_o,
      input  cdb_br_mask_o, cdb_src_o
   );

   modport slave (
      input  req_vld_i, req_tag_i, req_value_i,
      input  req_rob_idx_i, req_br_mask_i,
      input  rob_br_recovery_i, rob_br_pred_correct_i,
      input  rob_br_tag_fix_i,
      output req_gnt_o, cdb_vld_o, cdb_tag_o,
      output cdb_value_o, cdb_rob_idx_o,
      output cdb_br_mask_o, cdb_src_o
   );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: BR first, then LD/ALU/MULT round-robin, one registered broadcast.
// CDB_ARB_STARVE_EN adds wait counters letting a starved LD/ALU/MULT beat BR.
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif
`ifndef ZERO_REG
`define ZERO_REG {`PRF_IDX_W{1'b0}}
`endif

module cdb_arbiter #(
   parameter int unsigned STARVE_MAX = 8
) (
   input logic         clk,
   input logic         rst,
   cdb_arbiter_if.slave bus
);
   localparam int TW = `PRF_IDX_W;
   localparam int RW = `ROB_IDX_W + 1;
   localparam int MW = `BR_MASK_W;

   logic          rec;
   logic [3:0]    vld;
   logic [2:0]    starve;
   logic [1:0]    rr_q;
   logic [1:0]    p0, p1, p2;
   logic [1:0]    win;
   logic          hit;
   logic [3:0]    gnt;
   logic [TW-1:0] tag_sel;
   logic [63:0]   val_sel;
   logic [RW-1:0] rob_sel;
   logic [MW-1:0] mask_sel;

   logic          vld_q;
   logic [TW-1:0] tag_q;
   logic [63:0]   val_q;
   logic [RW-1:0] rob_q;
   logic [MW-1:0] mask_q;
   logic [1:0]    src_q;

   function automatic logic [1:0] nxt(input logic [1:0] x);
      unique case (x)
         2'd1:    nxt = 2'd2;
         2'd2:    nxt = 2'd3;
         default: nxt = 2'd1;
      endcase
   endfunction

   assign rec = bus.rob_br_recovery_i;
   assign vld = bus.req_vld_i;

`ifdef CDB_ARB_STARVE_EN
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

   logic [CW-1:0] wait_q [1:3];

   always_comb begin
      starve = '0;
      for (int i = 1; i < 4; i++)
         starve[i-1] = vld[i] && (wait_q[i] == CMAX);
   end

   // Counters only run while a request is held back.
   always_ff @(posedge clk) begin
      for (int i = 1; i < 4; i++) begin
         if (rst || rec || gnt[i] || !vld[i])
            wait_q[i] <= '0;
         else if (wait_q[i] != CMAX)
            wait_q[i] <= wait_q[i] + 1'b1;
      end
   end
`else
   logic unused;
   assign unused = |STARVE_MAX;
   assign starve = '0;
`endif

   assign p0 = rr_q;
   assign p1 = nxt(p0);
   assign p2 = nxt(p1);

   always_comb begin
      hit = 1'b0;
      win = 2'd0;
      if (!rst && !rec) begin
         if (starve[0]) begin
            hit = 1'b1;
            win = 2'd1;
         end else if (starve[1]) begin
            hit = 1'b1;
            win = 2'd2;
         end else if (starve[2]) begin
            hit = 1'b1;
            win = 2'd3;
         end else if (vld[0]) begin
            hit = 1'b1;
            win = 2'd0;
         end else if (vld[p0]) begin
            hit = 1'b1;
            win = p0;
         end else if (vld[p1]) begin
            hit = 1'b1;
            win = p1;
         end else if (vld[p2]) begin
            hit = 1'b1;
            win = p2;
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (hit)
         gnt[win] = 1'b1;
   end

   assign tag_sel  = bus.req_tag_i[int'(win)*TW +: TW];
   assign val_sel  = bus.req_value_i[int'(win)*64 +: 64];
   assign rob_sel  = bus.req_rob_idx_i[int'(win)*RW +: RW];
   assign mask_sel = bus.req_br_mask_i[int'(win)*MW +: MW];

   always_ff @(posedge clk) begin
      if (rst)
         rr_q <= 2'd1;
      else if (hit && win != 2'd0)
         rr_q <= nxt(win);
   end

   always_ff @(posedge clk) begin
      if (rst || !hit) begin
         vld_q  <= 1'b0;
         tag_q  <= `ZERO_REG;
         val_q  <= '0;
         rob_q  <= '0;
         mask_q <= '0;
         src_q  <= '0;
      end else begin
         vld_q  <= 1'b1;
         tag_q  <= tag_sel;
         val_q  <= val_sel;
         rob_q  <= rob_sel;
         // A branch resolving now must not linger in the broadcast mask.
         mask_q <= bus.rob_br_pred_correct_i ?
                   (mask_sel & ~bus.rob_br_tag_fix_i) : mask_sel;
         src_q  <= win;
      end
   end

   assign bus.req_gnt_o     = gnt;
   assign bus.cdb_vld_o     = vld_q & ~rec;
   assign bus.cdb_tag_o     = tag_q;
   assign bus.cdb_value_o   = val_q;
   assign bus.cdb_rob_idx_o = rob_q;
   assign bus.cdb_br_mask_o = mask_q;
   assign bus.cdb_src_o     = src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random bench for cdb_arbiter against a queue-free rule model.
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif
`ifndef ZERO_REG
`define ZERO_REG {`PRF_IDX_W{1'b0}}
`endif

module tb_cdb_arbiter;
   localparam int TW = `PRF_IDX_W;
   localparam int RW = `ROB_IDX_W + 1;
   localparam int MW = `BR_MASK_W;
   localparam int SMAX = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cdb_arbiter_if bus ();

   cdb_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   logic          v  [4];
   logic [TW-1:0] tg [4];
   logic [63:0]   vl [4];
   logic [RW-1:0] rb [4];
   logic [MW-1:0] mk [4];
   logic          rec, pc;
   logic [MW-1:0] fix;
   bit            drop;

   int            ptr;
   int            wt [4];
   logic          e_vld;
   logic [TW-1:0] e_tag;
   logic [63:0]   e_val;
   logic [RW-1:0] e_rob;
   logic [MW-1:0] e_mask;
   logic [1:0]    e_src;

   logic [3:0]    o_gnt;
   logic          o_vld;
   logic [TW-1:0] o_tag;
   logic [63:0]   o_val;
   logic [RW-1:0] o_rob;
   logic [MW-1:0] o_mask;
   logic [1:0]    o_src;

   int  got;
   logic [3:0] rr_exp [3];

   task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         bus.req_vld_i[i]               = v[i];
         bus.req_tag_i[i*TW +: TW]      = tg[i];
         bus.req_value_i[i*64 +: 64]    = vl[i];
         bus.req_rob_idx_i[i*RW +: RW]  = rb[i];
         bus.req_br_mask_i[i*MW +: MW]  = mk[i];
      end
      bus.rob_br_recovery_i     = rec;
      bus.rob_br_pred_correct_i = pc;
      bus.rob_br_tag_fix_i      = fix;
   endtask

   // Winner from the priority rules: starving, then BR, then RR from ptr.
   function automatic int pick();
      if (rst || rec) return -1;
`ifdef CDB_ARB_STARVE_EN
      for (int i = 1; i < 4; i++)
         if (v[i] && wt[i] >= SMAX) return i;
`endif
      if (v[0]) return 0;
      for (int k = 0; k < 3; k++) begin
         int j;
         j = 1 + (ptr - 1 + k) % 3;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic cyc();
      int w;
      logic [3:0] eg;
      drive();
      #2;
      w  = pick();
      eg = (w < 0) ? 4'b0 : 4'(1 << w);
      o_gnt  = bus.req_gnt_o;
      o_vld  = bus.cdb_vld_o;
      o_tag  = bus.cdb_tag_o;
      o_val  = bus.cdb_value_o;
      o_rob  = bus.cdb_rob_idx_o;
      o_mask = bus.cdb_br_mask_o;
      o_src  = bus.cdb_src_o;
      chk("gnt", o_gnt, eg);
      chk("cdb_vld", o_vld, e_vld && !rec);
      chk("cdb_tag", o_tag, e_tag);
      chk("cdb_value", o_val, e_val);
      chk("cdb_rob", o_rob, e_rob);
      chk("cdb_mask", o_mask, e_mask);
      chk("cdb_src", o_src, e_src);
      @(posedge clk);
      if (w >= 0) begin
         e_vld  = 1'b1;
         e_tag  = tg[w];
         e_val  = vl[w];
         e_rob  = rb[w];
         e_mask = pc ? (mk[w] & ~fix) : mk[w];
         e_src  = 2'(w);
      end else begin
         e_vld  = 1'b0;
         e_tag  = `ZERO_REG;
         e_val  = '0;
         e_rob  = '0;
         e_mask = '0;
         e_src  = '0;
      end
      for (int i = 1; i < 4; i++) begin
         if (rst || rec || w == i || !v[i]) wt[i] = 0;
         else if (wt[i] < SMAX) wt[i]++;
      end
      if (rst) ptr = 1;
      else if (w >= 1) ptr = w % 3 + 1;
      if (drop && w >= 0) v[w] = 1'b0;
      #1;
   endtask

   initial begin
      rr_exp[0] = 4'b0010;
      rr_exp[1] = 4'b0100;
      rr_exp[2] = 4'b1000;
      rec = 0; pc = 0; fix = '0; drop = 0; rst = 1;
      for (int i = 0; i < 4; i++) begin
         v[i] = 1'b1; tg[i] = TW'(i + 1);
         vl[i] = 64'h100 + 64'(i); rb[i] = RW'(i + 2);
         mk[i] = MW'(i); wt[i] = 0;
      end
      drive();
      repeat (2) @(posedge clk);
      #1;
      ptr = 1; e_vld = 0; e_tag = `ZERO_REG;
      e_val = '0; e_rob = '0; e_mask = '0; e_src = '0;
      // reset holds outputs and grants at zero
      repeat (2) cyc();
      rst = 0;

      // round-robin LD -> ALU -> MULT
      v[0] = 0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("rr_seq", o_gnt, rr_exp[k % 3]);
         if (k > 0) chk("rr_src", o_src, 64'(1 + (k - 1) % 3));
      end
      for (int i = 0; i < 4; i++) v[i] = 0;
      cyc();

      // BR hogging for 12 cycles against a waiting ALU
      got = 0;
      for (int c = 1; c <= 14; c++) begin
         v[0] = (c <= 12);
         v[2] = (got == 0);
         cyc();
         if (o_gnt[2] && got == 0) got = c;
      end
      v[0] = 0; v[2] = 0;
`ifdef CDB_ARB_STARVE_EN
      chk("starve_cycle", 64'(got), 64'd9);
`else
      chk("starve_cycle", 64'(got), 64'd13);
`endif
      cyc();

      // recovery right after an ALU grant
      v[2] = 1; tg[2] = TW'(5); vl[2] = 64'h1234;
      cyc();
      chk("alu_gnt", o_gnt, 4'b0100);
      for (int i = 0; i < 4; i++) v[i] = 1;
      rec = 1;
      cyc();
      chk("rec_vld", o_vld, 0);
      chk("rec_gnt", o_gnt, 0);
      chk("rec_held_tag", o_tag, 64'd5);
      for (int i = 0; i < 4; i++) v[i] = 0;
      rec = 0;
      cyc();
      chk("rec_clear_vld", o_vld, 0);
      chk("rec_clear_tag", o_tag, `ZERO_REG);

      // resolving branch stripped from captured mask
      v[3] = 1; mk[3] = 4'b0110; pc = 1; fix = 4'b0010;
      cyc();
      v[3] = 0; pc = 0; fix = '0;
      cyc();
      chk("fix_mask", o_mask, 4'b0100);
      chk("fix_src", o_src, 3);

      // reset mid-stream with all four requesting
      for (int i = 0; i < 4; i++) v[i] = 1;
      repeat (3) cyc();
      rst = 1;
      cyc();
      chk("rst_gnt", o_gnt, 0);
      rst = 0;
      cyc();
      chk("post_rst_vld", o_vld, 0);
      chk("post_rst_tag", o_tag, `ZERO_REG);
      chk("post_rst_br", o_gnt, 4'b0001);
      v[0] = 0;
      cyc();
      chk("post_rst_ld", o_gnt, 4'b0010);

      // random traffic, requests held until granted
      drop = 1;
      for (int i = 0; i < 4; i++) v[i] = 0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!v[i] && ($urandom % 2 == 0)) begin
               v[i]  = 1;
               tg[i] = TW'($urandom);
               vl[i] = {$urandom, $urandom};
               rb[i] = RW'($urandom);
               mk[i] = MW'($urandom);
            end
         end
         rec = ($urandom % 20 == 0);
         pc  = ($urandom % 5 == 0);
         fix = MW'(1 << ($urandom % MW));
         rst = ($urandom % 50 == 0);
         cyc();
      end
      rst = 0; rec = 0; pc = 0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 8, is the count of consecutive ungranted cycles after which a non-branch requester outranks the branch unit.
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 req_vld_i  input  4  per-requester valid; bit 0=BR, 1=LD, 2=ALU, 3=MULT.
REQ-005 req_tag_i  input  4*`PRF_IDX_W  destination tags, requester i at slice i.
REQ-006 req_value_i  input  4*64  writeback values.
REQ-007 req_rob_idx_i  input  4*(`ROB_IDX_W+1)  ROB indices.
REQ-008 req_br_mask_i  input  4*`BR_MASK_W  branch masks.
REQ-009 rob_br_recovery_i  input  1  mispredict recovery, squashes CDB traffic.
REQ-010 rob_br_pred_correct_i  input  1  branch resolved correct.
REQ-011 rob_br_tag_fix_i  input  `BR_MASK_W  one-hot tag of resolving branch.
REQ-012 req_gnt_o  output  4  one-hot-or-zero grant, combinational.
REQ-013 cdb_vld_o  output  1  broadcast valid, also PRF write enable.
REQ-014 cdb_tag_o  output  `PRF_IDX_W  broadcast tag.
REQ-015 cdb_value_o  output  64  PRF write value.
REQ-016 cdb_rob_idx_o  output  `ROB_IDX_W+1  ROB index for done marking.
REQ-017 cdb_br_mask_o  output  `BR_MASK_W  mask of broadcast entry.
REQ-018 cdb_src_o  output  2  index of granted requester now broadcasting.

Function
REQ-019 Requester holds valid and payload stable until the cycle its req_gnt_o bit is high; grant consumes the request that cycle.
REQ-020 At most one grant per cycle; no grant while rob_br_recovery_i=1.
REQ-021 Winner captured into output register at posedge; cdb_* valid exactly 1 cycle after grant (latency 1, throughput 1/cycle).
REQ-022 Priority: any starving requester (REQ-024) first, lowest index among starving; else BR; else LD/ALU/MULT per REQ-023.
REQ-023 LD/ALU/MULT arbitration round-robin: rr pointer names highest-priority requester, order LD->ALU->MULT->LD; after granting LD/ALU/MULT, pointer moves to next after winner; BR grants leave pointer unchanged.
REQ-024 Per LD/ALU/MULT wait counter: +1 each cycle valid && !gnt, saturating at STARVE_MAX; cleared on grant or valid low; requester "starving" when counter == STARVE_MAX.
REQ-025 Captured br_mask = req_br_mask & ~rob_br_tag_fix_i when rob_br_pred_correct_i=1, else unchanged.
REQ-026 Held output register with rob_br_pred_correct_i=1: cdb_br_mask_o bit tag_fix cleared next cycle.
REQ-027 rob_br_recovery_i=1: cdb_vld_o forced 0 combinationally same cycle; output register cleared (vld=0) next cycle; wait counters cleared; rr pointer kept.
REQ-028 No valid request (or recovery): next cdb_vld_o=0, cdb_tag_o=`ZERO_REG, value/rob_idx/br_mask/src=0.
REQ-029 Simultaneous recovery and pred_correct: recovery wins.

Reset
REQ-030 rst=1 at posedge: cdb_vld_o=0, cdb_tag_o=`ZERO_REG, other cdb_* outputs 0, wait counters 0, rr pointer=LD.
REQ-031 req_gnt_o=0 whenever rst=1; reset mid-stream drops the registered winner and any in-flight request is not granted.

Configuration
REQ-032 Macro CDB_ARB_STARVE_EN: defined -> wait counters and starvation override per REQ-022/REQ-024; undefined -> no counters, STARVE_MAX ignored, BR always highest, then round-robin.

Verification
REQ-033 LD+ALU+MULT valid continuously, BR idle, pointer=LD -> grants LD,ALU,MULT,LD...; cdb_src_o 1,2,3,1 one cycle later.
REQ-034 BR valid 12 cycles continuously, ALU valid, STARVE_EN defined, STARVE_MAX=8 -> ALU granted cycle 9 ahead of BR; undefined -> ALU granted only after BR drops.
REQ-035 ALU granted tag 5 value 0x1234, recovery asserted next cycle -> cdb_vld_o=0 that cycle, no grant, register cleared after.
REQ-036 MULT granted mask 4'b0110, pred_correct tag_fix 4'b0010 same cycle -> cdb_br_mask_o=4'b0100 next cycle.
REQ-037 rst mid-stream with all four valid -> req_gnt_o=0, cdb_vld_o=0, cdb_tag_o=`ZERO_REG next cycle; after release first grant BR, then LD.
